bus_ram_responder: RTL and testbench
====================================

// Module: bus_ram_responder
// PURPOSE
//   Read/write RAM responder on the CPU memory bus, downstream of mem_controller.
//   Accepts one transfer at a time from the arbitrated bus (HTRANS/HADDR/HWRITE/HWDATA).
//   Inserts a fixed number of wait states and answers with HRDATA/HREADY/HRESP.
//   Gives mem_access a writable data store alongside the read-only irom.
// PARAMETERS
//   ADDR_BASE    64'h0000_0000_8000_0000  byte address of word 0
//   DEPTH        1024                     number of 64-bit words (power of 2)
//   WAIT_CYCLES  2                        wait states between accept and response (0..15)
// PORTS
//   CLK     in   1   clock, rising edge
//   RESET   in   1   asynchronous, active-low reset
//   HTRANS  in   1   transfer request this cycle
//   HADDR   in   64  byte address
//   HWRITE  in   1   1 = write, 0 = read
//   HSIZE   in   2   0=byte 1=half 2=word 3=dword
//   HWDATA  in   64  write data, element in LSBs
//   HRDATA  out  64  read data, element zero-extended in LSBs
//   HREADY  out  1   1 = idle/accepting, or response valid this cycle
//   HRESP   out  1   1 = error response (valid only while HREADY=1 in RESP)
// BEHAVIOUR
//   Reset (RESET=0, any time): state=IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter=0.
//   - In-flight transfer aborted; no write committed. RAM contents are not cleared.
//   States: IDLE, WAIT, RESP.
//   Accept: HTRANS=1 and HREADY=1 in IDLE or RESP. Latch HADDR, HWRITE, HSIZE, HWDATA.
//   - Next state WAIT (counter loaded with WAIT_CYCLES-1); RESP directly if WAIT_CYCLES=0.
//   - HTRANS=0 in IDLE: stay IDLE. HTRANS=0 in RESP: go to IDLE.
//   WAIT: HREADY=0. Counter decrements each cycle; at 0, next state is RESP.
//   - HTRANS is ignored while in WAIT.
//   RESP: lasts one cycle. HREADY=1. HRESP and HRDATA are valid.
//   - Latency: accept edge to RESP cycle is WAIT_CYCLES+1 clocks.
//   - A new accept in RESP gives back-to-back transfers with no IDLE cycle.
//   Decode: off = HADDR - ADDR_BASE; word = off[3+:log2(DEPTH)]; lane = off[2:0].
//   Error (HRESP=1, HRDATA=0, no write) when either holds:
//   - HADDR < ADDR_BASE, or off >= DEPTH*8 (out of range);
//   - lane is not a multiple of 2^HSIZE (misaligned).
//   Read: HRDATA = (mem[word] >> 8*lane), masked to 8<<HSIZE bits, zero-extended.
//   Write: performed on the clock edge that enters RESP. Only the bytes
//   lane .. lane+2^HSIZE-1 are updated, from HWDATA LSBs. HRDATA=0 for writes.
//   Read-after-write to the same address returns the new data; there is no bypass hazard.
//   HRDATA and HRESP return to 0 on any cycle that is not RESP.
//   Arithmetic: offset compare is full 64-bit unsigned. No wrap past the top of memory.
// TESTING
//   Reset, then idle -> HREADY=1, HRESP=0, HRDATA=0 held for 10 cycles.
//   Dword write 0x1122334455667788 @0x80000008, then dword read @0x80000008, WAIT_CYCLES=2
//   -> read returns 0x1122334455667788 with HREADY=1 exactly 3 clocks after accept.
//   Byte write 0xAB @0x80000013 into word holding 0, then dword read @0x80000010
//   -> 0x000000AB000000 (byte 3 set); half read @0x80000012 -> 0xAB00.
//   Read @0x7FFFFFF8, read @0x80000000+DEPTH*8, and half read @0x80000001
//   -> HRESP=1, HRDATA=0; a following read shows the RAM unchanged.
//   Back-to-back: HTRANS held 1 for 4 reads with WAIT_CYCLES=0 -> HREADY=1 every cycle,
//   one response per clock, no IDLE cycles between them.
//   Assert RESET during WAIT of a dword write 0xFFFF.. @0x80000000
//   -> HREADY=1 immediately; a later read of that address returns its old value.

Source files
------------

// File: rtl/bus_ram_responder.sv
// Single-port 64-bit RAM responder for the CPU memory bus: one transfer at a time,
// a fixed number of wait states, byte-lane reads/writes with range and alignment errors.
module bus_ram_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    logic [63:0] addr_p0;
    logic        write_p0;
    logic [1:0]  size_p0;
    logic [63:0] wdata_p0;

    logic [63:0] cur_addr;
    logic        cur_write;
    logic [1:0]  cur_size;
    logic [63:0] cur_wdata;

    logic [63:0] off;
    logic [AW-1:0] word;
    logic [2:0]  lane;
    logic        cur_err;
    logic        accept;
    logic        enter_resp;

    logic [63:0] mem [DEPTH];

    function automatic logic [2:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 3'b000;
            2'd1:    lane_mask = 3'b001;
            2'd2:    lane_mask = 3'b011;
            default: lane_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 8'h01;
            2'd1:    size_bytes = 8'h03;
            2'd2:    size_bytes = 8'h0F;
            default: size_bytes = 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] rd_extract(input logic [63:0] w, input logic [2:0] ln,
                                               input logic [1:0] size);
        logic [63:0] s;
        s = w >> {ln, 3'b000};
        case (size)
            2'd0:    rd_extract = {56'd0, s[7:0]};
            2'd1:    rd_extract = {48'd0, s[15:0]};
            2'd2:    rd_extract = {32'd0, s[31:0]};
            default: rd_extract = s;
        endcase
    endfunction

    function automatic logic [63:0] wr_merge(input logic [63:0] old, input logic [63:0] wd,
                                             input logic [2:0] ln, input logic [1:0] size);
        logic [63:0] s;
        logic [7:0]  be;
        s        = wd << {ln, 3'b000};
        be       = size_bytes(size) << ln;
        wr_merge = old;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) wr_merge[8*i +: 8] = s[8*i +: 8];
        end
    endfunction

    assign HREADY = (state != S_WAIT);
    assign accept = HTRANS && HREADY;

    // With no wait states the response is formed on the accept edge itself,
    // so the live bus request is used instead of the latched copy.
    always_comb begin
        cur_addr  = addr_p0;
        cur_write = write_p0;
        cur_size  = size_p0;
        cur_wdata = wdata_p0;
        if (WAIT_CYCLES == 0) begin
            cur_addr  = HADDR;
            cur_write = HWRITE;
            cur_size  = HSIZE;
            cur_wdata = HWDATA;
        end
    end

    assign off     = cur_addr - ADDR_BASE;
    assign word    = off[3 +: AW];
    assign lane    = off[2:0];
    assign cur_err = (cur_addr < ADDR_BASE) || (off >= SPAN) ||
                     ((lane & lane_mask(cur_size)) != 3'b000);

    assign enter_resp = ((state == S_WAIT) && (wait_cnt == 4'd0)) ||
                        (accept && (WAIT_CYCLES == 0));

    // p0: request captured at accept
    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_p0  <= HADDR;
            write_p0 <= HWRITE;
            size_p0  <= HSIZE;
            wdata_p0 <= HWDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && enter_resp && cur_write && !cur_err)
            mem[word] <= wr_merge(mem[word], cur_wdata, lane, cur_size);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            HRDATA   <= 64'd0;
            HRESP    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                        wait_cnt <= CNT_INIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase

            HRESP  <= enter_resp && cur_err;
            HRDATA <= (enter_resp && !cur_err && !cur_write)
                      ? rd_extract(mem[word], lane, cur_size) : 64'd0;
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench for bus_ram_responder: a 2-wait-state instance for functional and
// reset-abort cases, and a zero-wait instance for back-to-back streaming.
module tb_bus_ram_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;

    logic        trans_s = 0, write_s = 0;
    logic [63:0] addr_s = 0, wdata_s = 0;
    logic [1:0]  size_s = 0;
    logic [63:0] rdata_s;
    logic        ready_s, resp_s;

    logic        trans_f = 0, write_f = 0;
    logic [63:0] addr_f = 0, wdata_f = 0;
    logic [1:0]  size_f = 0;
    logic [63:0] rdata_f;
    logic        ready_f, resp_f;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        int          acc;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t q_s[$];
    exp_t q_f[$];

    bus_ram_responder #(.WAIT_CYCLES(2)) dut_s (
        .CLK(CLK), .RESET(RESET), .HTRANS(trans_s), .HADDR(addr_s), .HWRITE(write_s),
        .HSIZE(size_s), .HWDATA(wdata_s), .HRDATA(rdata_s), .HREADY(ready_s), .HRESP(resp_s)
    );

    bus_ram_responder #(.WAIT_CYCLES(0)) dut_f (
        .CLK(CLK), .RESET(RESET), .HTRANS(trans_f), .HADDR(addr_f), .HWRITE(write_f),
        .HSIZE(size_f), .HWDATA(wdata_f), .HRDATA(rdata_f), .HREADY(ready_f), .HRESP(resp_f)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (q_s.size() > 0) begin
            if (cyc == q_s[0].due) begin
                chk("s_hready_resp", 64'(ready_s), 64'd1);
                chk("s_hresp", 64'(resp_s), 64'(q_s[0].err));
                chk("s_hrdata", rdata_s, q_s[0].data);
                void'(q_s.pop_front());
            end else if (cyc >= q_s[0].acc) begin
                chk("s_hready_wait", 64'(ready_s), 64'd0);
                chk("s_hrdata_wait", rdata_s, 64'd0);
            end
        end
    end

    always @(negedge CLK) begin
        if (q_f.size() > 0 && cyc == q_f[0].due) begin
            chk("f_hready", 64'(ready_f), 64'd1);
            chk("f_hresp", 64'(resp_f), 64'(q_f[0].err));
            chk("f_hrdata", rdata_f, q_f[0].data);
            void'(q_f.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge following the response.
    task automatic go_s(input logic w, input logic [63:0] a, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [63:0] ed, input logic ee);
        exp_t e;
        trans_s = 1; write_s = w; addr_s = a; size_s = sz; wdata_s = wd;
        e.acc = cyc + 1; e.due = cyc + 3; e.data = ed; e.err = ee;
        q_s.push_back(e);
        @(posedge CLK); #1;
        trans_s = 0;
        for (int i = 0; i < 20 && q_s.size() > 0; i++) begin
            @(posedge CLK); #1;
        end
        if (q_s.size() != 0) begin
            chk("s_timeout", 64'(q_s.size()), 64'd0);
            q_s.delete();
        end
    endtask

    task automatic b2b(input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] ed);
        exp_t e;
        trans_f = 1; write_f = w; addr_f = a; size_f = 2'd3; wdata_f = wd;
        e.acc = cyc + 1; e.due = cyc + 1; e.data = ed; e.err = 1'b0;
        q_f.push_back(e);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hready", 64'(ready_s), 64'd1);
        chk("rst_hresp", 64'(resp_s), 64'd0);
        chk("rst_hrdata", rdata_s, 64'd0);
        RESET = 1;

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_hready", 64'(ready_s), 64'd1);
            chk("idle_hresp", 64'(resp_s), 64'd0);
            chk("idle_hrdata", rdata_s, 64'd0);
        end
        @(posedge CLK); #1;

        // dword write/read, then sub-word reads of the same word
        go_s(1, 64'h8000_0008, 2'd3, 64'h1122_3344_5566_7788, 64'd0, 0);
        go_s(0, 64'h8000_0008, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 0);
        go_s(0, 64'h8000_000C, 2'd2, 64'd0, 64'h0000_0000_1122_3344, 0);
        go_s(0, 64'h8000_000F, 2'd0, 64'd0, 64'h0000_0000_0000_0011, 0);

        // byte write into a zeroed word
        go_s(1, 64'h8000_0010, 2'd3, 64'd0, 64'd0, 0);
        go_s(1, 64'h8000_0013, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 0);
        go_s(0, 64'h8000_0010, 2'd3, 64'd0, 64'h0000_0000_AB00_0000, 0);
        go_s(0, 64'h8000_0012, 2'd1, 64'd0, 64'h0000_0000_0000_AB00, 0);

        // error cases: below base, past the end, misaligned read and write
        go_s(0, 64'h7FFF_FFF8, 2'd3, 64'd0, 64'd0, 1);
        go_s(0, 64'h8000_2000, 2'd3, 64'd0, 64'd0, 1);
        go_s(0, 64'h8000_0001, 2'd1, 64'd0, 64'd0, 1);
        go_s(1, 64'h8000_000A, 2'd2, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1);
        go_s(1, 64'h0000_0000_0000_0008, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1);
        go_s(0, 64'h8000_0008, 2'd3, 64'd0, 64'h1122_3344_5566_7788, 0);

        // last word is in range
        go_s(1, 64'h8000_1FF8, 2'd3, 64'hCAFE_F00D_0BAD_BEEF, 64'd0, 0);
        go_s(0, 64'h8000_1FF8, 2'd3, 64'd0, 64'hCAFE_F00D_0BAD_BEEF, 0);

        // reset during WAIT of a write must not commit it
        go_s(1, 64'h8000_0000, 2'd3, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
        trans_s = 1; write_s = 1; addr_s = 64'h8000_0000; size_s = 2'd3;
        wdata_s = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge CLK); #1;
        chk("abort_in_wait", 64'(ready_s), 64'd0);
        trans_s = 0;
        RESET = 0;
        #1;
        chk("abort_hready", 64'(ready_s), 64'd1);
        chk("abort_hresp", 64'(resp_s), 64'd0);
        @(posedge CLK); #1;
        RESET = 1;
        @(posedge CLK); #1;
        go_s(0, 64'h8000_0000, 2'd3, 64'd0, 64'h0123_4567_89AB_CDEF, 0);

        // zero-wait instance: streaming writes then streaming reads
        for (int i = 0; i < 4; i++)
            b2b(1, 64'h8000_0000 + 64'(8*i), 64'hA5A5_0000_0000_0000 + 64'(i * 17), 64'd0);
        for (int i = 0; i < 4; i++)
            b2b(0, 64'h8000_0000 + 64'(8*i), 64'd0, 64'hA5A5_0000_0000_0000 + 64'(i * 17));
        trans_f = 0;
        for (int i = 0; i < 10 && q_f.size() > 0; i++) begin
            @(posedge CLK); #1;
        end
        if (q_f.size() != 0) begin
            chk("f_timeout", 64'(q_f.size()), 64'd0);
            q_f.delete();
        end
        @(negedge CLK);
        chk("f_idle_hrdata", rdata_f, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
